// File: rtl/result_serializer.sv
// result_serializer: buffers N-lane result vectors in a DEPTH-entry FIFO and streams lanes out lane 0 first.
// Optional RESULT_SERIALIZER_RELU_EN clamps negative output elements to zero.
module result_serializer #(
    parameter int Width = 8,
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [N*Width-1:0]   in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Width-1:0]     out_data,
    output logic                 out_last,
    output logic                 busy
);
    localparam int LW = $clog2(N);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {EMPTY, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [N*Width:0]     mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [N*Width-1:0]   sh_q, sh_d;
    logic                 sh_last_q, sh_last_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic                 push, pop, fire, at_end;
    logic [Width-1:0]     elem;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // in_ready depends only on registered count, so a same-cycle pop never frees a full slot
    assign in_ready = count_q != CW'(DEPTH);
    assign busy     = (count_q != '0) || (state_q == SHIFT);

    always_comb begin
        push      = in_valid && in_ready;
        fire      = (state_q == SHIFT) && out_ready;
        at_end    = lane_q == LW'(N - 1);
        pop       = (count_q != '0) && ((state_q == EMPTY) || (fire && at_end));
        state_d   = state_q;
        lane_d    = lane_q;
        sh_d      = sh_q;
        sh_last_d = sh_last_q;
        if (pop) begin
            state_d              = SHIFT;
            lane_d               = '0;
            {sh_last_d, sh_d}    = mem_q[rd_ptr_q];
        end else if (fire) begin
            state_d = at_end ? EMPTY : SHIFT;
            lane_d  = at_end ? lane_q : lane_q + LW'(1);
        end
        wr_ptr_d = push ? inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? inc(rd_ptr_q) : rd_ptr_q;
        count_d  = (push && !pop) ? count_q + CW'(1) :
                   (!push && pop) ? count_q - CW'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sh_q      <= '0;
            sh_last_q <= 1'b0;
            lane_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sh_q      <= sh_d;
            sh_last_q <= sh_last_d;
            lane_q    <= lane_d;
        end
    end

    always_comb begin
        elem      = sh_q[lane_q*Width +: Width];
        out_valid = state_q == SHIFT;
`ifdef RESULT_SERIALIZER_RELU_EN
        out_data  = (out_valid && !elem[Width-1]) ? elem : '0;
`else
        out_data  = out_valid ? elem : '0;
`endif
        out_last  = out_valid && at_end && sh_last_q;
    end
endmodule

// File: doc/result_serializer.md
# result_serializer

Output-side companion to the parallel compute controller: captures the N-lane result vector produced on each compute step, buffers whole vectors in a small FIFO, and streams the lanes out one element per cycle over a valid/ready handshake. It sits between the parallel datapath (which writes one vector per computing cycle) and the narrow downstream consumer (which reads scalars). Backpressure is returned to the controller through `in_ready`.

## Interface
- `Width`, 8: bits per lane/element.
- `N`, 4: lanes per vector; N ≥ 2.
- `DEPTH`, 4: vector FIFO depth; DEPTH ≥ 1, any integer (no power-of-two requirement).
- `clk`  input  1  clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  vector present on `in_data`.
- `in_data`  input  N*Width  lane i at bits [i*Width +: Width].
- `in_last`  input  1  vector is the last of a batch.
- `in_ready`  output  1  FIFO can accept a vector.
- `out_valid`  output  1  `out_data` holds a valid element.
- `out_ready`  input  1  consumer accepts the element.
- `out_data`  output  Width  current element.
- `out_last`  output  1  element is lane N-1 of a vector pushed with `in_last`.
- `busy`  output  1  FIFO non-empty or serializer loaded.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes {`in_data`, `in_last`} to the FIFO tail.
- `in_ready` = (FIFO count < DEPTH); registered-state only, no combinational path from `out_ready`. When full, push is refused even if a pop occurs in the same cycle.
- Serializer FSM, states: EMPTY and SHIFT.
  - EMPTY: `out_valid`=0. If FIFO non-empty, pop head into shift register, lane counter ← 0, go to SHIFT.
  - SHIFT: `out_valid`=1, `out_data` = lane[lane counter]. On `out_valid && out_ready`: if lane counter < N-1, increment it; else (lane N-1) pop the next vector if FIFO non-empty (lane counter ← 0, stay in SHIFT), otherwise go to EMPTY.
- Lane order: lane 0 first, lane N-1 last.
- `out_last` = 1 only in SHIFT at lane N-1 of a vector whose stored `in_last`=1.
- Without handshake (`out_ready`=0), `out_data`/`out_last`/`out_valid` hold stable.
- FIFO count: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Pointers wrap from DEPTH-1 to 0. Count width $clog2(DEPTH+1).
- Lane counter width $clog2(N); never exceeds N-1.
- `busy` = (count != 0) || (state == SHIFT).

## Timing
- Reset (asynchronous, any time, including mid-vector): state EMPTY, count 0, pointers 0, lane counter 0; `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `in_ready`=1 right after reset. In-flight data is discarded.
- Latency: vector pushed at edge t with serializer EMPTY is popped at edge t+1; lane 0 is valid after edge t+1.
- Throughput: back-to-back vectors with `out_ready` held high give one element per cycle, with no bubble between vectors.
- The FIFO is only ever read by a pop, so DEPTH=1 still reaches full throughput: the shift register acts as a second slot.

## Configuration
- `RESULT_SERIALIZER_RELU_EN` defined: each element is interpreted as signed two's-complement. A negative element is output as 0 (ReLU, applied combinationally on the `out_data` path); stored data is unchanged.
- Not defined: `out_data` is the raw lane value.

## Test plan
- Reset, then push 0x04030201 with `in_last`=1 and `out_ready`=1 → `out_data` 01,02,03,04 on consecutive cycles starting 2 edges after the push; `out_last` high only with 04; then `busy`=0.
- Push 3 vectors back-to-back with `out_ready`=1 → 12 consecutive valid cycles with no gap.
- `out_ready`=0, push DEPTH+1 vectors → `in_ready` drops once count=DEPTH (shift register loaded plus DEPTH queued). Output holds lane 0 stable. Releasing `out_ready` drains all vectors in order.
- Full FIFO with pop and `in_valid` in the same cycle → push refused. Count decrements, and `in_ready` rises the next cycle.
- Assert `rst_n`=0 at lane 2 of a vector with 2 vectors queued → all outputs 0 immediately. After release, no stale data appears.
- With the macro defined, push 0x7F80FF01 → outputs 01, 00, 00, 7F; without the macro → 01, FF, 80, 7F.
